// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed seven-segment scan controller, optional PWM dimming via SEG7_DIMMING_EN
module seg7_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int CLK_FREQ_HZ  = 25_000_000,
    parameter int SLOT_HZ      = 1000,
    parameter int GUARD_CYCLES = 4,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_blank,
    input  logic                  i_load,
    input  logic [3:0]            i_bright,
    output logic [DIGITS-1:0]     o_an,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic                  o_frame,
    output logic                  o_busy
);

    localparam int SLOT_CYCLES = CLK_FREQ_HZ / SLOT_HZ;
    localparam int PCNT_W      = $clog2(SLOT_CYCLES);
    localparam int IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SLOT_CYCLES - 1);
    localparam logic [PCNT_W-1:0] GUARD_END = PCNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [1:0]          rst_sync_q;
    logic                rst_n_int;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                slot_end, wrap, gate_open, lit;
    logic [4*DIGITS-1:0] pend_value_q, act_value_q;
    logic [DIGITS-1:0]   pend_dp_q, pend_blank_q, act_dp_q, act_blank_q;
    logic                pend_valid_q;
    logic [3:0]          nibble;
    logic [6:0]          hex;
    logic [DIGITS-1:0]   an_d, an_q;
    logic [6:0]          seg_d, seg_q;
    logic                dp_d, dp_q, frame_q;

    // Reset asserts immediately, releases two clocks after rstn rises
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync_q <= 2'b00;
        else       rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Slot prescaler and digit index next-state
    always_comb begin
        slot_end = (pcnt_q == PCNT_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);
        pcnt_d   = slot_end ? '0 : pcnt_q + PCNT_W'(1);
        idx_d    = idx_q;
        if (slot_end) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end

    // Scan position registers
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            pcnt_q <= '0;
            idx_q  <= '0;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
        end
    end

`ifdef SEG7_DIMMING_EN
    logic [3:0] pwm_q, bright_q;
    // PWM phase restarts every slot; brightness is latched only at period boundaries
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            pwm_q    <= 4'd0;
            bright_q <= 4'hF;
        end else begin
            pwm_q <= slot_end ? 4'd0 : pwm_q + 4'd1;
            if (slot_end || pwm_q == 4'hF) bright_q <= i_bright;
        end
    end
    assign gate_open = (pwm_q <= bright_q);
`else
    logic unused_bright;
    assign unused_bright = ^i_bright;
    assign gate_open     = 1'b1;
`endif

    // Double buffer: loads land in pending, commit to active only at frame wrap
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            pend_valid_q <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
        end else begin
            if (wrap && pend_valid_q) begin
                act_value_q <= pend_value_q;
                act_dp_q    <= pend_dp_q;
                act_blank_q <= pend_blank_q;
            end
            if (i_load) begin
                pend_value_q <= i_value;
                pend_dp_q    <= i_dp;
                pend_blank_q <= i_blank;
                pend_valid_q <= 1'b1;
            end else if (wrap) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    // Hex decode and lit qualification for the current digit
    always_comb begin
        nibble = act_value_q[{idx_q, 2'b00} +: 4];
        case (nibble)
            4'h0: hex = 7'b1111110;
            4'h1: hex = 7'b0110000;
            4'h2: hex = 7'b1101101;
            4'h3: hex = 7'b1111001;
            4'h4: hex = 7'b0110011;
            4'h5: hex = 7'b1011011;
            4'h6: hex = 7'b1011111;
            4'h7: hex = 7'b1110000;
            4'h8: hex = 7'b1111111;
            4'h9: hex = 7'b1111011;
            4'hA: hex = 7'b1110111;
            4'hB: hex = 7'b0011111;
            4'hC: hex = 7'b1001110;
            4'hD: hex = 7'b0111101;
            4'hE: hex = 7'b1001111;
            default: hex = 7'b1000111;
        endcase
        lit   = (pcnt_q >= GUARD_END) && !act_blank_q[idx_q] && gate_open;
        an_d  = (lit ? (DIGITS'(1) << idx_q) : '0) ^ {DIGITS{ACTIVE_LOW}};
        seg_d = (lit ? hex : 7'd0) ^ {7{ACTIVE_LOW}};
        dp_d  = (lit & act_dp_q[idx_q]) ^ ACTIVE_LOW;
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            an_q    <= {DIGITS{ACTIVE_LOW}};
            seg_q   <= {7{ACTIVE_LOW}};
            dp_q    <= ACTIVE_LOW;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= wrap;
        end
    end

    assign o_an    = an_q;
    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_frame = frame_q;
    assign o_busy  = pend_valid_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

`ifdef SEG7_DIMMING_EN
    localparam int LIT_B3 = 8;
    localparam int LIT_B0 = 2;
`else
    localparam int LIT_B3 = 36;
    localparam int LIT_B0 = 36;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] i_value_a = '0;
    logic [7:0]  i_dp_a = '0, i_blank_a = '0;
    logic        i_load_a = 1'b0;
    logic [3:0]  i_bright_a = 4'hF;
    logic [7:0]  o_an_a;
    logic [6:0]  o_seg_a;
    logic        o_dp_a, o_frame_a, o_busy_a;
    logic [7:0]  i_value_b = '0;
    logic [1:0]  i_dp_b = '0, i_blank_b = '0;
    logic        i_load_b = 1'b0;
    logic [3:0]  i_bright_b = 4'hF;
    logic [1:0]  o_an_b;
    logic [6:0]  o_seg_b;
    logic        o_dp_b, o_frame_b, o_busy_b;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    seg7_scan_ctrl #(.DIGITS(8), .CLK_FREQ_HZ(1000), .SLOT_HZ(100), .GUARD_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rstn(rstn), .i_value(i_value_a), .i_dp(i_dp_a), .i_blank(i_blank_a),
        .i_load(i_load_a), .i_bright(i_bright_a), .o_an(o_an_a), .o_seg(o_seg_a),
        .o_dp(o_dp_a), .o_frame(o_frame_a), .o_busy(o_busy_a));

    seg7_scan_ctrl #(.DIGITS(2), .CLK_FREQ_HZ(4000), .SLOT_HZ(100), .GUARD_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rstn(rstn), .i_value(i_value_b), .i_dp(i_dp_b), .i_blank(i_blank_b),
        .i_load(i_load_b), .i_bright(i_bright_b), .o_an(o_an_b), .o_seg(o_seg_b),
        .o_dp(o_dp_b), .o_frame(o_frame_b), .o_busy(o_busy_b));

    always #5 clk = ~clk;

    // Expected {an, seg, dp} at step t (1..80) after a frame pulse, 10-cycle slots, 4-cycle guard
    function automatic logic [15:0] model_a(input logic [31:0] v, input logic [7:0] dp,
                                            input logic [7:0] bl, input int t);
        int k, p;
        logic [7:0] an;
        logic [6:0] seg;
        logic       d;
        logic [3:0] nib;
        k   = (t - 1) / 10;
        p   = (t - 1) % 10;
        an  = 8'hFF;
        seg = 7'h7F;
        d   = 1'b1;
        nib = v[k*4 +: 4];
        if (p >= 4 && !bl[k]) begin
            an  = ~(8'd1 << k);
            seg = ~hex_tab[nib];
            d   = ~dp[k];
        end
        return {an, seg, d};
    endfunction

    task automatic wait_frame_a(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_frame_a !== 1'b1 && n < budget);
        checks++;
        if (o_frame_a !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame_a got no pulse within %0d cycles, required a pulse", budget);
        end
    endtask

    task automatic wait_frame_b(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_frame_b !== 1'b1 && n < budget);
        checks++;
        if (o_frame_b !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame_b got no pulse within %0d cycles, required a pulse", budget);
        end
    endtask

    task automatic test_reset();
        int dark_bad = 0;
        int frames = 0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_an_a !== 8'hFF) begin errors++; $display("FAIL reset_an got %h required ff", o_an_a); end
        checks++; if (o_seg_a !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h required 7f", o_seg_a); end
        checks++; if (o_dp_a !== 1'b1) begin errors++; $display("FAIL reset_dp got %b required 1", o_dp_a); end
        checks++; if (o_frame_a !== 1'b0) begin errors++; $display("FAIL reset_frame got %b required 0", o_frame_a); end
        checks++; if (o_busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", o_busy_a); end
        checks++; if (o_an_b !== 2'b11) begin errors++; $display("FAIL reset_an_b got %b required 11", o_an_b); end
        rstn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_an_a !== 8'hFF || o_seg_a !== 7'h7F || o_dp_a !== 1'b1) dark_bad++;
            if (o_frame_a === 1'b1) frames++;
        end
        checks++; if (dark_bad != 0) begin errors++; $display("FAIL reset_dark got %0d lit cycles required 0", dark_bad); end
        checks++; if (frames != 1) begin errors++; $display("FAIL reset_first_frame got %0d pulses required 1", frames); end
    endtask

    task automatic test_scan();
        logic [15:0] exp16;
        i_value_a = 32'h01234567; i_blank_a = 8'h00; i_dp_a = 8'h00; i_bright_a = 4'hF;
        i_load_a = 1'b1;
        @(negedge clk);
        i_load_a = 1'b0;
        checks++; if (o_busy_a !== 1'b1) begin errors++; $display("FAIL scan_busy got %b required 1", o_busy_a); end
        wait_frame_a(100);
        checks++; if (o_busy_a !== 1'b0) begin errors++; $display("FAIL scan_commit_busy got %b required 0", o_busy_a); end
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            exp16 = model_a(32'h01234567, 8'h00, 8'h00, t);
            checks++;
            if ({o_an_a, o_seg_a, o_dp_a} !== exp16) begin
                errors++; $display("FAIL scan t=%0d got %h required %h", t, {o_an_a, o_seg_a, o_dp_a}, exp16);
            end
            checks++;
            if (o_frame_a !== 1'(t == 80)) begin
                errors++; $display("FAIL scan_frame t=%0d got %b required %b", t, o_frame_a, t == 80);
            end
        end
    endtask

    task automatic test_tear();
        logic [15:0] exp16;
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            exp16 = model_a(32'h01234567, 8'h00, 8'h00, t);
            checks++;
            if ({o_an_a, o_seg_a, o_dp_a} !== exp16) begin
                errors++; $display("FAIL tear_old t=%0d got %h required %h", t, {o_an_a, o_seg_a, o_dp_a}, exp16);
            end
            if (t == 35) begin i_value_a = 32'h11111111; i_load_a = 1'b1; end
            if (t == 36) begin
                i_load_a = 1'b0;
                checks++; if (o_busy_a !== 1'b1) begin errors++; $display("FAIL tear_busy got %b required 1", o_busy_a); end
            end
        end
        checks++; if (o_busy_a !== 1'b0) begin errors++; $display("FAIL tear_commit_busy got %b required 0", o_busy_a); end
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            exp16 = model_a(32'h11111111, 8'h00, 8'h00, t);
            checks++;
            if ({o_an_a, o_seg_a, o_dp_a} !== exp16) begin
                errors++; $display("FAIL tear_new t=%0d got %h required %h", t, {o_an_a, o_seg_a, o_dp_a}, exp16);
            end
        end
    endtask

    task automatic test_collision();
        logic [15:0] exp16;
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            exp16 = model_a(32'h11111111, 8'h00, 8'h00, t);
            checks++;
            if ({o_an_a, o_seg_a, o_dp_a} !== exp16) begin
                errors++; $display("FAIL coll_pre t=%0d got %h required %h", t, {o_an_a, o_seg_a, o_dp_a}, exp16);
            end
            i_load_a = 1'b0;
            if (t == 5)  begin i_value_a = 32'h55555555; i_load_a = 1'b1; end
            if (t == 20) begin i_value_a = 32'h89ABCDEF; i_load_a = 1'b1; end
            if (t == 79) begin i_value_a = 32'hFEDCBA98; i_load_a = 1'b1; end
        end
        checks++; if (o_frame_a !== 1'b1) begin errors++; $display("FAIL coll_wrap_frame got %b required 1", o_frame_a); end
        checks++; if (o_busy_a !== 1'b1) begin errors++; $display("FAIL coll_wrap_busy got %b required 1", o_busy_a); end
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            exp16 = model_a(32'h89ABCDEF, 8'h00, 8'h00, t);
            checks++;
            if ({o_an_a, o_seg_a, o_dp_a} !== exp16) begin
                errors++; $display("FAIL coll_b t=%0d got %h required %h", t, {o_an_a, o_seg_a, o_dp_a}, exp16);
            end
            if (t == 40) begin
                checks++; if (o_busy_a !== 1'b1) begin errors++; $display("FAIL coll_busy_mid got %b required 1", o_busy_a); end
            end
        end
        checks++; if (o_busy_a !== 1'b0) begin errors++; $display("FAIL coll_busy_end got %b required 0", o_busy_a); end
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            exp16 = model_a(32'hFEDCBA98, 8'h00, 8'h00, t);
            checks++;
            if ({o_an_a, o_seg_a, o_dp_a} !== exp16) begin
                errors++; $display("FAIL coll_c t=%0d got %h required %h", t, {o_an_a, o_seg_a, o_dp_a}, exp16);
            end
        end
    endtask

    task automatic test_blank_dp();
        logic [15:0] exp16;
        int dp_lit = 0;
        i_value_a = 32'h01234567; i_blank_a = 8'h02; i_dp_a = 8'h01; i_load_a = 1'b1;
        @(negedge clk);
        i_load_a = 1'b0;
        wait_frame_a(100);
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            exp16 = model_a(32'h01234567, 8'h01, 8'h02, t);
            checks++;
            if ({o_an_a, o_seg_a, o_dp_a} !== exp16) begin
                errors++; $display("FAIL blank_dp t=%0d got %h required %h", t, {o_an_a, o_seg_a, o_dp_a}, exp16);
            end
            if (o_dp_a === 1'b0) dp_lit++;
        end
        checks++; if (dp_lit != 6) begin errors++; $display("FAIL blank_dp_count got %0d required 6", dp_lit); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] exp16;
        repeat (30) @(negedge clk);
        i_value_a = 32'h88888888; i_blank_a = 8'h00; i_dp_a = 8'hFF; i_load_a = 1'b1;
        @(negedge clk);
        i_load_a = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (o_an_a !== 8'hFF) begin errors++; $display("FAIL mid_rst_an got %h required ff", o_an_a); end
        checks++; if (o_busy_a !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b required 0", o_busy_a); end
        checks++; if (o_seg_a !== 7'h7F || o_dp_a !== 1'b1) begin
            errors++; $display("FAIL mid_rst_seg got %h/%b required 7f/1", o_seg_a, o_dp_a);
        end
        rstn = 1'b1;
        wait_frame_a(200);
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            exp16 = model_a(32'h0, 8'h00, 8'hFF, t);
            checks++;
            if ({o_an_a, o_seg_a, o_dp_a, o_busy_a} !== {exp16, 1'b0}) begin
                errors++; $display("FAIL mid_rst_dark t=%0d got %h/%b required %h/0", t, {o_an_a, o_seg_a, o_dp_a}, o_busy_a, exp16);
            end
        end
    endtask

    task automatic test_dimming();
        int lit0, lit1, seg_bad;
        logic [3:0] levels [3] = '{4'd3, 4'd0, 4'd15};
        int exp_lit [3] = '{LIT_B3, LIT_B0, 36};
        i_value_b = 8'h80; i_blank_b = 2'b00; i_dp_b = 2'b00; i_load_b = 1'b1;
        @(negedge clk);
        i_load_b = 1'b0;
        for (int l = 0; l < 3; l++) begin
            i_bright_b = levels[l];
            wait_frame_b(200);
            lit0 = 0; lit1 = 0; seg_bad = 0;
            for (int t = 1; t <= 80; t++) begin
                @(negedge clk);
                if (o_an_b === 2'b10) begin
                    lit0++;
                    if (o_seg_b !== 7'b0000001) seg_bad++;
                end
                if (o_an_b === 2'b01) begin
                    lit1++;
                    if (o_seg_b !== 7'b0000000) seg_bad++;
                end
            end
            checks++; if (lit0 != exp_lit[l]) begin errors++; $display("FAIL dim_d0 bright=%0d got %0d required %0d", levels[l], lit0, exp_lit[l]); end
            checks++; if (lit1 != exp_lit[l]) begin errors++; $display("FAIL dim_d1 bright=%0d got %0d required %0d", levels[l], lit1, exp_lit[l]); end
            checks++; if (seg_bad != 0) begin errors++; $display("FAIL dim_seg bright=%0d got %0d bad required 0", levels[l], seg_bad); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear();
        test_collision();
        test_blank_dp();
        test_reset_midframe();
        test_dimming();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment scan controller for the board-level display on the Nexys A7 and Boolean boards. It drives any number of common-anode digits from one hex/decimal-point/blank image. The image is double-buffered so that updates commit only at frame boundaries, which gives tear-free display. An anti-ghosting guard and optional PWM dimming are built in. It sits between the veerwolf_core display register interface and the board's AN/CA..CG pins, and replaces the fixed 8-digit scan logic.

## Interface
- DIGITS, 8, number of digits scanned (1..16)
- CLK_FREQ_HZ, 25_000_000, clk frequency
- SLOT_HZ, 1000, per-digit slot rate; SLOT_CYCLES = CLK_FREQ_HZ/SLOT_HZ (integer, ≥ GUARD_CYCLES+16)
- GUARD_CYCLES, 4, anode-off cycles at start of each slot
- ACTIVE_LOW, 1, 1: o_an/o_seg/o_dp asserted low; 0: asserted high
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- i_value  in  4*DIGITS  hex nibble per digit, digit k = [4k+3:4k], digit 0 rightmost
- i_dp  in  DIGITS  decimal point per digit
- i_blank  in  DIGITS  1 = digit dark
- i_load  in  1  single-cycle strobe: capture i_value/i_dp/i_blank into pending buffer
- i_bright  in  4  duty level, on-fraction = (i_bright+1)/16
- o_an  out  DIGITS  one-hot digit enables
- o_seg  out  7  segments {a,b,c,d,e,f,g}, a = bit 6
- o_dp  out  1  decimal point
- o_frame  out  1  one-cycle pulse at each frame wrap
- o_busy  out  1  pending image not yet committed

## Operation
- Pending buffer: i_load copies inputs into pending and sets pending_valid. A second load before commit overwrites pending (last wins).
- Active buffer: feeds the scan. Reset value is value=0, dp=0, blank=all ones.
- Prescaler pcnt counts 0..SLOT_CYCLES-1. At terminal count, digit index idx advances. When idx wraps from DIGITS-1 to 0, it is a frame wrap.
- At frame wrap: if pending_valid, active ← pending and pending_valid ← 0. o_frame pulses for the same cycle.
- i_load in the frame-wrap cycle: the previously pending image commits; the new image is captured into pending; o_busy stays 1.
- o_busy = pending_valid.
- Digit idx is lit when all of the following hold:
  - pcnt ≥ GUARD_CYCLES
  - active blank[idx] = 0
  - PWM gate is open
- When idx is lit: o_an has only bit idx asserted, o_seg = hex decode of nibble idx, o_dp = dp[idx]. Otherwise all of o_an, o_seg and o_dp are deasserted.
- Hex decode (active-high abcdefg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. Invert when ACTIVE_LOW.
- i_bright is sampled every cycle; a change takes effect on the next PWM period.

## Timing
- All outputs are registered and change one clk after the internal pcnt/idx state that causes them.
- Frame length = DIGITS*SLOT_CYCLES cycles.
- Load-to-display latency: from the i_load cycle to the next frame wrap, plus 1 cycle for the commit, plus GUARD_CYCLES.
- Reset (async assert, sync-safe deassert internally, two-flop):
  - pcnt=0, idx=0, pwm=0, pending_valid=0
  - o_an/o_seg/o_dp deasserted (all 1s when ACTIVE_LOW)
  - o_frame=0, o_busy=0
- Reset mid-frame discards both the pending and the active images. Scanning restarts at digit 0, all blanked.
- DIGITS=1: every slot terminal is a frame wrap; o_an toggles only through the guard.

## Configuration
- SEG7_DIMMING_EN defined:
  - 4-bit pwm counter increments every clk and resets to 0 at each slot start.
  - Gate is open when pwm ≤ i_bright. This gives (i_bright+1) on-cycles per 16 outside the guard.
- SEG7_DIMMING_EN undefined:
  - pwm counter is removed and the gate is always open.
  - i_bright is ignored and left unconnected internally.

## Test plan
- Reset: hold rstn=0 → o_an=8'hFF, o_seg=7'h7F, o_dp=1, o_frame=0, o_busy=0. After release, all digits stay dark for one full frame.
- Scan with CLK_FREQ_HZ=1000, SLOT_HZ=100 (SLOT_CYCLES=10), i_load with i_value=32'h01234567, blank=0, bright=15:
  - o_busy=1 until the wrap; o_frame every 80 cycles.
  - In the slot for digit 0 after commit: o_an=8'hFE and o_seg=7'b0001111 for cycles 4..9; cycles 0..3 fully dark.
- Tear-free update: i_load 32'h11111111 mid-frame → remaining slots of that frame still show the old image. The new image appears from digit 0 of the next frame.
- Load collision: i_load A, then i_load B, then i_load C exactly on the wrap cycle → B commits; C becomes pending; o_busy=1 until the following wrap, then C is displayed.
- Blank/dp: i_blank=8'h02, i_dp=8'h01 → digit 1 slot all dark; digit 0 has o_dp=0 (asserted) while lit.
- Dimming (SEG7_DIMMING_EN, SLOT_CYCLES=40, GUARD_CYCLES=4, bright=3) → digit lit on pwm 0..3 of each 16 after guard; count exactly the lit cycles per slot and check them against the expected number. Undefined macro → lit for 36 cycles per slot regardless of i_bright.
